ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/mesm6_pkg.sv | 21 ++
 rtl/ifetch_buf.sv | 54 +++++
 rtl/ifetch.sv | 161 ++++++++++++++++
 tb/tb_ifetch.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesm6_pkg.sv
// Shared types for the MESM-6 instruction fetch unit: word, half-word and
// word-address types plus the fetch state encoding.
package mesm6_pkg;

  typedef logic [47:0] word_t;
  typedef logic [23:0] insn_t;
  typedef logic [14:0] waddr_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_GAP   = 2'd1,
    ST_LEFT  = 2'd2,
    ST_RIGHT = 2'd3
  } state_t;

  // Word addresses wrap naturally at the top of the 15-bit space.
  function automatic waddr_t waddr_inc(input waddr_t a);
    return a + 15'd1;
  endfunction

endpackage

// File: rtl/ifetch_buf.sv
// Two-entry 48-bit word queue used by ifetch when IFETCH_PREFETCH_EN is
// defined; entry0 is always the word currently being issued.
`ifdef IFETCH_PREFETCH_EN
module ifetch_buf
  import mesm6_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  word_t      push_data,
  output word_t      head,
  output logic [1:0] count
);

  word_t entry0;
  word_t entry1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= push_data;
          else               entry1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = entry0;

endmodule
`endif

// File: rtl/ifetch.sv
// Instruction fetch: reads 48-bit words and issues them as left/right 24-bit
// half-words. Define IFETCH_PREFETCH_EN for a second buffer that prefetches pc+1.
module ifetch
  import mesm6_pkg::*;
#(
  parameter waddr_t RESET_PC = 15'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [14:0] o_addr,
  output logic        o_read,
  input  logic [47:0] i_data,
  input  logic        i_done,
  input  logic        i_jump,
  input  logic [14:0] i_jump_addr,
  input  logic        i_jump_right,
  output logic        o_valid,
  output logic [23:0] o_insn,
  output logic [14:0] o_pc,
  output logic        o_right,
  input  logic        i_ready
);

  state_t state;
  waddr_t fetch_addr;
  waddr_t pc;
  logic   entry_right;
  logic   xfer;
  logic   mem_busy;
  logic   have_word;
  word_t  head;

  assign xfer = o_valid & i_ready;

`ifdef IFETCH_PREFETCH_EN
  logic       pf_req;
  logic       word_next;
  logic       buf_push;
  logic       buf_pop;
  logic [1:0] buf_count;

  assign mem_busy  = (state == ST_FETCH) | pf_req;
  assign have_word = (buf_count != 2'd0);
  assign word_next = (buf_count == 2'd2) | (pf_req & i_done);
  assign buf_push  = mem_busy & i_done & ~i_jump;
  assign buf_pop   = (state == ST_RIGHT) & xfer & ~i_jump;

  ifetch_buf u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (buf_push),
    .pop       (buf_pop),
    .flush     (i_jump),
    .push_data (i_data),
    .head      (head),
    .count     (buf_count)
  );

  // A prefetch that is still in flight when RIGHT retires becomes the
  // ordinary FETCH, so o_read and o_addr stay continuous across the handover.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pf_req <= 1'b0;
    end else if (i_jump) begin
      pf_req <= 1'b0;
    end else if (pf_req && (i_done || (state == ST_RIGHT && xfer))) begin
      pf_req <= 1'b0;
    end else if ((state == ST_GAP && have_word && entry_right) ||
                 (state == ST_LEFT && xfer)) begin
      pf_req <= 1'b1;
    end
  end
`else
  word_t word_buf;
  logic  word_valid;

  assign mem_busy  = (state == ST_FETCH);
  assign have_word = word_valid;
  assign head      = word_buf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_buf   <= '0;
      word_valid <= 1'b0;
    end else if (i_jump) begin
      word_valid <= 1'b0;
    end else if (state == ST_FETCH && i_done) begin
      word_buf   <= i_data;
      word_valid <= 1'b1;
    end else if (state == ST_RIGHT && xfer) begin
      word_valid <= 1'b0;
    end
  end
`endif

  // A jump beats every other event; GAP without a buffered word means the
  // redirect target still has to be fetched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_FETCH;
      fetch_addr  <= RESET_PC;
      pc          <= RESET_PC;
      entry_right <= 1'b0;
    end else if (i_jump) begin
      state       <= ST_GAP;
      fetch_addr  <= i_jump_addr;
      entry_right <= i_jump_right;
    end else begin
      case (state)
        ST_FETCH: begin
          if (i_done) begin
            state <= ST_GAP;
            pc    <= fetch_addr;
          end
        end
        ST_GAP: begin
          if (!have_word) begin
            state <= ST_FETCH;
          end else if (entry_right) begin
            state       <= ST_RIGHT;
            entry_right <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
            fetch_addr  <= waddr_inc(pc);
`endif
          end else begin
            state <= ST_LEFT;
          end
        end
        ST_LEFT: begin
          if (xfer) begin
            state <= ST_RIGHT;
`ifdef IFETCH_PREFETCH_EN
            fetch_addr <= waddr_inc(pc);
`endif
          end
        end
        ST_RIGHT: begin
          if (xfer) begin
            pc <= waddr_inc(pc);
`ifdef IFETCH_PREFETCH_EN
            state <= word_next ? ST_LEFT : ST_FETCH;
`else
            state      <= ST_FETCH;
            fetch_addr <= waddr_inc(pc);
`endif
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Reset gates the request combinationally so an in-flight read drops at once.
  assign o_read  = reset_n & mem_busy;
  assign o_addr  = fetch_addr;
  assign o_valid = (state == ST_LEFT) | (state == ST_RIGHT);
  assign o_right = (state == ST_RIGHT);
  assign o_pc    = pc;
  assign o_insn  = o_right ? head[23:0] : head[47:24];

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: memory model, transfer scoreboard and one
// task per scenario. The back-to-back test needs IFETCH_PREFETCH_EN.
`timescale 1ns/1ps
module tb_ifetch;

  localparam logic [14:0] RESET_PC = 15'h0000;

  logic        clk;
  logic        reset_n;
  logic [14:0] o_addr;
  logic        o_read;
  logic [47:0] i_data;
  logic        i_done;
  logic        i_jump;
  logic [14:0] i_jump_addr;
  logic        i_jump_right;
  logic        o_valid;
  logic [23:0] o_insn;
  logic [14:0] o_pc;
  logic        o_right;
  logic        i_ready;

  int checks = 0;
  int errors = 0;
  int mem_lat = 2;

  typedef struct {
    logic [14:0] pc;
    logic        right;
    logic [23:0] insn;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  ifetch #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .o_addr       (o_addr),
    .o_read       (o_read),
    .i_data       (i_data),
    .i_done       (i_done),
    .i_jump       (i_jump),
    .i_jump_addr  (i_jump_addr),
    .i_jump_right (i_jump_right),
    .o_valid      (o_valid),
    .o_insn       (o_insn),
    .o_pc         (o_pc),
    .o_right      (o_right),
    .i_ready      (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] half_of(input logic [14:0] a, input logic r);
    return r ? {1'b1, 8'h5A, a} : {1'b0, 8'hA5, a};
  endfunction

  function automatic logic [47:0] word_of(input logic [14:0] a);
    return {half_of(a, 1'b0), half_of(a, 1'b1)};
  endfunction

  task automatic push_exp(input logic [14:0] a, input logic r);
    exp_t e;
    e.pc = a;
    e.right = r;
    e.insn = half_of(a, r);
    sb.push_back(e);
  endtask

  // Memory: answers after mem_lat waiting cycles, checks address hold and the idle gap.
  initial begin : memory_model
    int          mem_wait;
    logic [14:0] req_addr;
    logic        prev_done;
    mem_wait = 0;
    req_addr = '0;
    prev_done = 1'b0;
    i_done = 1'b0;
    i_data = '0;
    forever begin
      @(negedge clk);
      if (prev_done) begin
        checks++;
        if (o_read !== 1'b0) begin
          errors++;
          $display("[TB] FAIL read_gap: got o_read=%0b after done, expected 0", o_read);
        end
      end
      if (reset_n && o_read) begin
        if (mem_wait == 0) begin
          req_addr = o_addr;
        end else begin
          checks++;
          if (o_addr !== req_addr) begin
            errors++;
            $display("[TB] FAIL addr_hold: got o_addr=%h, expected %h", o_addr, req_addr);
          end
        end
        if (mem_wait == mem_lat) begin
          i_done = 1'b1;
          i_data = word_of(o_addr);
          mem_wait = 0;
        end else begin
          i_done = 1'b0;
          mem_wait++;
        end
      end else begin
        i_done = 1'b0;
        mem_wait = 0;
      end
      prev_done = i_done;
    end
  end

  // Scoreboard: every transfer pops the oldest expected half-word.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (reset_n && o_valid && i_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_xfer: got pc=%h right=%0b insn=%h, expected no transfer",
                   o_pc, o_right, o_insn);
        end else begin
          mon_e = sb.pop_front();
          if ({o_pc, o_right, o_insn} !== {mon_e.pc, mon_e.right, mon_e.insn}) begin
            errors++;
            $display("[TB] FAIL xfer: got pc=%h right=%0b insn=%h, expected pc=%h right=%0b insn=%h",
                     o_pc, o_right, o_insn, mon_e.pc, mon_e.right, mon_e.insn);
          end
        end
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: got %0d transfers pending, expected 0", name, sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
    i_ready = 1'b0;
  endtask

  task automatic wait_read(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!o_read && n < 50);
    checks++;
    if (o_read !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_wait_read: got o_read=%0b, expected 1", name, o_read);
    end
  endtask

  task automatic jump_to(input logic [14:0] a, input logic r);
    i_jump = 1'b1;
    i_jump_addr = a;
    i_jump_right = r;
    @(negedge clk);
    i_jump = 1'b0;
  endtask

  task automatic test_reset;
    int lat;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({o_read, o_valid, o_right} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got read/valid/right=%b, expected 000", {o_read, o_valid, o_right});
    end
    checks++;
    if (o_addr !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL reset_addr: got %h, expected %h", o_addr, RESET_PC);
    end
    checks++;
    if (o_pc !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL reset_pc: got %h, expected %h", o_pc, RESET_PC);
    end
    checks++;
    if (o_insn !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_insn: got %h, expected 000000", o_insn);
    end
    push_exp(15'h0000, 1'b0);
    push_exp(15'h0000, 1'b1);
    push_exp(15'h0001, 1'b0);
    push_exp(15'h0001, 1'b1);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    checks++;
    if ({o_read, o_addr} !== {1'b1, RESET_PC}) begin
      errors++;
      $display("[TB] FAIL first_fetch: got read=%0b addr=%h, expected read=1 addr=%h", o_read, o_addr, RESET_PC);
    end
    lat = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (o_valid) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("[TB] FAIL first_valid_latency: got cycle %0d, expected 4", lat);
    end
    drain("order", 40);
  endtask

  task automatic test_stall;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!o_valid && n < 50);
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_wait_valid: got o_valid=%0b, expected 1", o_valid);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({o_valid, o_read, o_pc, o_right, o_insn} !== {1'b1, 1'b0, 15'h0002, 1'b0, half_of(15'h0002, 1'b0)}) begin
        errors++;
        $display("[TB] FAIL stall_hold: got valid=%0b read=%0b pc=%h right=%0b insn=%h, expected 1 0 0002 0 %h",
                 o_valid, o_read, o_pc, o_right, o_insn, half_of(15'h0002, 1'b0));
      end
    end
    push_exp(15'h0002, 1'b0);
    push_exp(15'h0002, 1'b1);
    @(negedge clk);
    i_ready = 1'b1;
    drain("stall", 20);
  endtask

  task automatic test_jump;
    wait_read("jump");
    jump_to(15'h1234, 1'b1);
    #1;
    checks++;
    if ({o_read, o_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL jump_drop: got read/valid=%b, expected 00", {o_read, o_valid});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({o_read, o_addr} !== {1'b1, 15'h1234}) begin
      errors++;
      $display("[TB] FAIL jump_fetch: got read=%0b addr=%h, expected read=1 addr=1234", o_read, o_addr);
    end
    push_exp(15'h1234, 1'b1);
    i_ready = 1'b1;
    drain("jump", 30);
  endtask

  task automatic test_wrap;
    int n;
    @(negedge clk);
    jump_to(15'h7FFF, 1'b0);
    push_exp(15'h7FFF, 1'b0);
    push_exp(15'h7FFF, 1'b1);
    push_exp(15'h0000, 1'b0);
    push_exp(15'h0000, 1'b1);
    i_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(o_read && o_addr !== 15'h7FFF) && n < 50);
    checks++;
    if ({o_read, o_addr} !== {1'b1, 15'h0000}) begin
      errors++;
      $display("[TB] FAIL wrap_addr: got read=%0b addr=%h, expected read=1 addr=0000", o_read, o_addr);
    end
    drain("wrap", 40);
  endtask

  task automatic test_reset_mid_fetch;
    wait_read("rst");
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({o_read, o_valid, o_addr} !== {1'b0, 1'b0, RESET_PC}) begin
      errors++;
      $display("[TB] FAIL rst_async: got read=%0b valid=%0b addr=%h, expected 0 0 %h",
               o_read, o_valid, o_addr, RESET_PC);
    end
    repeat (2) @(posedge clk);
    push_exp(RESET_PC, 1'b0);
    push_exp(RESET_PC, 1'b1);
    i_ready = 1'b1;
    #1;
    reset_n = 1'b1;
    #1;
    checks++;
    if ({o_read, o_addr} !== {1'b1, RESET_PC}) begin
      errors++;
      $display("[TB] FAIL rst_restart: got read=%0b addr=%h, expected read=1 addr=%h", o_read, o_addr, RESET_PC);
    end
    drain("rst", 30);
  endtask

`ifdef IFETCH_PREFETCH_EN
  task automatic test_back_to_back;
    int n;
    int bubbles;
    mem_lat = 0;
    @(negedge clk);
    jump_to(15'h0010, 1'b0);
    for (int w = 0; w < 4; w++) begin
      push_exp(15'h0010 + 15'(w), 1'b0);
      push_exp(15'h0010 + 15'(w), 1'b1);
    end
    i_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!o_valid && n < 30);
    bubbles = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      #1;
      if (!o_valid) bubbles++;
    end
    checks++;
    if (bubbles != 0 || n >= 30) begin
      errors++;
      $display("[TB] FAIL back_to_back: got %0d bubble cycles (wait %0d), expected 0", bubbles, n);
    end
    drain("b2b", 20);
    mem_lat = 2;
  endtask
`endif

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    i_jump = 1'b0;
    i_jump_addr = '0;
    i_jump_right = 1'b0;
    i_ready = 1'b0;
    test_reset();
    test_stall();
    test_jump();
    test_wrap();
    test_reset_mid_fetch();
`ifdef IFETCH_PREFETCH_EN
    test_back_to_back();
`endif
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
